shift_sin_pout: RTL
===================

# shift_sin_pout

Serial-in, parallel-out byte receiver for the Raspberry Pi → TI direction of the TIPI CPLD serial link. The Pi drives a bit clock, a data line and a frame-enable line, all asynchronous to the CPLD clock. The block synchronizes them, shifts bits MSB-first into a byte, and presents each completed byte in a held register with a valid/ack handshake toward the TI-side register logic. It is the receiving counterpart of the existing parallel-load, MSB-first serial transmitter.

## Interface
Parameters:
- none

Ports:
- clk  in  1  CPLD system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- sclk  in  1  serial bit clock from Pi; async to clk; data is sampled on its rising edge.
- sdata  in  1  serial data from Pi, MSB first.
- sle  in  1  frame enable from Pi; async; high = frame active.
- data  out  8  last completed byte, held until the next transfer.
- valid  out  1  high while `data` holds an unacknowledged byte.
- ack  in  1  one-cycle pulse from the consumer; clears `valid`.
- overrun  out  1  sticky; a byte completed while `valid`=1 and no `ack`.
- dout  out  8  debug: live shift register contents.
- parity_err  out  1  present only with SHIFT_SIN_PARITY_EN (see Configuration).

## Operation
- `sclk`, `sdata` and `sle` each pass through a 2-flop synchronizer (s1, s2). A third flop on `sclk` (s3) provides edge detection: `rise = sclk_s2 & ~sclk_s3`.
- Bit counter `cnt` counts 0..N-1, with N=8 (N=9 with parity).
- When `sle_s2`=0: `cnt`←0, the partial byte is discarded, and `rise` is ignored. `data`, `valid` and `overrun` are unaffected.
- When `sle_s2`=1 and `rise`=1: `shreg`←{shreg[6:0], sdata_s2}, and `cnt` increments.
- On the rise that completes bit N-1, `cnt`←0 and a transfer occurs:
  - Case `valid`=0, or `ack`=1 in the same cycle: `data`←new byte, `valid`←1.
  - Case `valid`=1 and `ack`=0: the new byte is dropped, `data` is kept, and `overrun`←1.
- `ack` with `valid`=1 and no transfer in that cycle: `valid`←0. `ack` with `valid`=0 is ignored.
- `overrun` is cleared only by `reset`.
- `dout` = `shreg`, updated on every shift.
- `sle` dropping mid-byte (after 1..N-1 bits): the partial byte is lost, with no transfer and no flag.
- Reset mid-frame: all state is cleared. The Pi must deassert `sle` and restart the frame.

## Timing
- Reset values: `data`=0x00, `valid`=0, `overrun`=0, `parity_err`=0, `dout`=0x00; `cnt`, `shreg` and all synchronizer flops = 0.
- The `sclk` rising edge at the pin becomes `rise` 2–3 clk edges later. The shift and transfer happen on the following edge. `valid` is high no later than 4 clk edges after the final `sclk` rise.
- Constraints on the Pi side:
  - `sclk` high ≥3 clk periods and low ≥3 clk periods.
  - `sdata` stable from 1 clk period before to 4 clk periods after each `sclk` rise.
  - `sle` high ≥3 clk periods before the first `sclk` rise.
- `ack` is sampled every cycle, and a single-cycle pulse is sufficient. `valid` drops on the edge that samples `ack`.
- Back-to-back bytes without `sle` toggling are allowed, since the counter wraps.

## Configuration
- SHIFT_SIN_PARITY_EN defined:
  - Frame is 9 bits: 8 data bits MSB-first, then an odd-parity bit.
  - On each accepted transfer, `parity_err`←1 if XOR of all 9 bits is 0, else 0. The byte is still delivered.
  - `parity_err` is not updated on a dropped (overrun) byte.
  - The `parity_err` port exists.
- Not defined: frame is 8 bits, and the `parity_err` port and logic are absent.

## Test plan
- Reset, then idle: all outputs 0. Toggling `sclk` with `sle`=0 → `valid` stays 0 and `dout` stays 0x00.
- Send 0xA5 (8 rises, `sle`=1) → `data`=0xA5 and `valid`=1 within 4 clk of the last rise. `ack` pulse → `valid`=0, `data` holds 0xA5.
- Send 0x3C without ack, then 0xC3 → `data`=0x3C, `overrun`=1. `ack` → `valid`=0, and `overrun` stays 1 until `reset`.
- Send 4 bits, drop `sle`, raise it again, send 0x81 → `data`=0x81 with no overrun.
- Hold `ack` high continuously while sending 0x11, 0x22 back-to-back → `data` updates to each byte and `overrun`=0.
- With SHIFT_SIN_PARITY_EN: send 0x01 with parity bit 0 → `parity_err`=0. Send 0x03 with parity bit 0 → `parity_err`=1, `data`=0x03.

Source files
------------

// File: rtl/shift_sin_pout.sv
// Serial-in, parallel-out byte receiver (MSB first) with a valid/ack holding register.
// Define SHIFT_SIN_PARITY_EN for 9-bit frames with a trailing odd-parity bit and the parity_err port.
module shift_sin_pout (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       sdata,
  input  logic       sle,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       overrun,
`ifdef SHIFT_SIN_PARITY_EN
  output logic       parity_err,
`endif
  output logic [7:0] dout
);

`ifdef SHIFT_SIN_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd8;
`else
  localparam logic [3:0] LAST_BIT = 4'd7;
`endif

  // Bit order in the synchronizer vectors: 0 = sclk, 1 = sdata, 2 = sle
  logic [2:0] pins;
  logic [2:0] pin_s1_reg;
  logic [2:0] pin_s2_reg;
  logic       sclk_s3_reg;

  assign pins = {sle, sdata, sclk};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (reset) begin
          pin_s1_reg[gi] <= 1'b0;
          pin_s2_reg[gi] <= 1'b0;
        end else begin
          pin_s1_reg[gi] <= pins[gi];
          pin_s2_reg[gi] <= pin_s1_reg[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) sclk_s3_reg <= 1'b0;
    else       sclk_s3_reg <= pin_s2_reg[0];
  end

  logic       sclk_s2;
  logic       sdata_s2;
  logic       sle_s2;
  logic       rise;
  logic       shift_en;
  logic       last_bit;
  logic       accept;
  logic [7:0] shreg_next;
  logic [7:0] new_byte;

  logic [3:0] cnt_reg;
  logic [7:0] shreg_reg;
  logic [7:0] data_reg;
  logic       valid_reg;
  logic       overrun_reg;

  assign sclk_s2  = pin_s2_reg[0];
  assign sdata_s2 = pin_s2_reg[1];
  assign sle_s2   = pin_s2_reg[2];
  assign rise     = sclk_s2 & ~sclk_s3_reg;
  assign shift_en = sle_s2 & rise;
  assign last_bit = shift_en && (cnt_reg == LAST_BIT);
  assign accept   = last_bit && (!valid_reg || ack);

`ifdef SHIFT_SIN_PARITY_EN
  // The parity bit never enters the data shifter; the byte is complete after bit 7.
  assign shreg_next = last_bit ? shreg_reg : {shreg_reg[6:0], sdata_s2};
  assign new_byte   = shreg_reg;

  logic parity_err_reg;

  always_ff @(posedge clk) begin
    if (reset)       parity_err_reg <= 1'b0;
    else if (accept) parity_err_reg <= ~(^{shreg_reg, sdata_s2});
  end

  assign parity_err = parity_err_reg;
`else
  assign shreg_next = {shreg_reg[6:0], sdata_s2};
  assign new_byte   = shreg_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= 4'd0;
      shreg_reg <= 8'h00;
    end else if (!sle_s2) begin
      cnt_reg <= 4'd0;
    end else if (shift_en) begin
      shreg_reg <= shreg_next;
      cnt_reg   <= last_bit ? 4'd0 : cnt_reg + 4'd1;
    end
  end

  // A completed byte takes priority over an ack of the previous one in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg    <= 8'h00;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (last_bit) begin
      if (accept) begin
        data_reg  <= new_byte;
        valid_reg <= 1'b1;
      end else begin
        overrun_reg <= 1'b1;
      end
    end else if (ack && valid_reg) begin
      valid_reg <= 1'b0;
    end
  end

  assign data    = data_reg;
  assign valid   = valid_reg;
  assign overrun = overrun_reg;
  assign dout    = shreg_reg;

endmodule
